// File: rtl/ysyx_25030077_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN alternates grants between IFU and LSU on contention.
module ysyx_25030077_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_ar_valid,
  output logic              ifu_ar_ready,
  input  logic [ADDR_W-1:0] ifu_ar_addr,
  output logic              ifu_r_valid,
  input  logic              ifu_r_ready,
  output logic [DATA_W-1:0] ifu_r_data,
  input  logic              lsu_ar_valid,
  output logic              lsu_ar_ready,
  input  logic [ADDR_W-1:0] lsu_ar_addr,
  input  logic [2:0]        lsu_ar_strb,
  output logic              lsu_r_valid,
  input  logic              lsu_r_ready,
  output logic [DATA_W-1:0] lsu_r_data,
  input  logic              lsu_aw_valid,
  output logic              lsu_aw_ready,
  input  logic [ADDR_W-1:0] lsu_aw_addr,
  input  logic              lsu_w_valid,
  output logic              lsu_w_ready,
  input  logic [DATA_W-1:0] lsu_w_data,
  input  logic [2:0]        lsu_w_strb,
  output logic              lsu_b_valid,
  input  logic              lsu_b_ready,
  output logic [1:0]        lsu_b_resp,
  output logic              io_axi_ar_valid,
  input  logic              io_axi_ar_ready,
  output logic [ADDR_W-1:0] io_axi_ar_addr,
  output logic [2:0]        io_axi_ar_strb,
  input  logic              io_axi_r_valid,
  output logic              io_axi_r_ready,
  input  logic [DATA_W-1:0] io_axi_r_data,
  output logic              io_axi_aw_valid,
  input  logic              io_axi_aw_ready,
  output logic [ADDR_W-1:0] io_axi_aw_addr,
  output logic              io_axi_w_valid,
  input  logic              io_axi_w_ready,
  output logic [DATA_W-1:0] io_axi_w_data,
  output logic [2:0]        io_axi_w_strb,
  input  logic              io_axi_b_valid,
  output logic              io_axi_b_ready,
  input  logic [1:0]        io_axi_b_resp
);

  typedef enum logic [1:0] {StIdle, StIfuRd, StLsuRd, StLsuWr} state_e;

  state_e state_q, state_d;
  logic   addr_done_q, addr_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   aw_hs, w_hs, wr_both_done;
  logic   lsu_wr_req;

  assign lsu_wr_req = lsu_aw_valid | lsu_w_valid;

`ifdef ARB_ROUND_ROBIN_EN
  // last_gnt: 0 = IFU, 1 = LSU
  logic last_gnt_q, last_gnt_d;
  logic lsu_wins;
  assign lsu_wins = (lsu_wr_req | lsu_ar_valid) & (!ifu_ar_valid | !last_gnt_q);
`endif

  always_comb begin
    state_d         = state_q;
    addr_done_d     = addr_done_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d      = last_gnt_q;
`endif
    aw_hs           = 1'b0;
    w_hs            = 1'b0;
    wr_both_done    = 1'b0;
    ifu_ar_ready    = 1'b0;
    ifu_r_valid     = 1'b0;
    ifu_r_data      = '0;
    lsu_ar_ready    = 1'b0;
    lsu_r_valid     = 1'b0;
    lsu_r_data      = '0;
    lsu_aw_ready    = 1'b0;
    lsu_w_ready     = 1'b0;
    lsu_b_valid     = 1'b0;
    lsu_b_resp      = '0;
    io_axi_ar_valid = 1'b0;
    io_axi_ar_addr  = '0;
    io_axi_ar_strb  = '0;
    io_axi_r_ready  = 1'b0;
    io_axi_aw_valid = 1'b0;
    io_axi_aw_addr  = '0;
    io_axi_w_valid  = 1'b0;
    io_axi_w_data   = '0;
    io_axi_w_strb   = '0;
    io_axi_b_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (lsu_wins) begin
          state_d    = lsu_wr_req ? StLsuWr : StLsuRd;
          last_gnt_d = 1'b1;
        end else if (ifu_ar_valid) begin
          state_d    = StIfuRd;
          last_gnt_d = 1'b0;
        end
`else
        if (lsu_wr_req)        state_d = StLsuWr;
        else if (lsu_ar_valid) state_d = StLsuRd;
        else if (ifu_ar_valid) state_d = StIfuRd;
`endif
      end

      StIfuRd: begin
        if (!addr_done_q) begin
          io_axi_ar_valid = ifu_ar_valid;
          io_axi_ar_addr  = ifu_ar_addr;
          io_axi_ar_strb  = 3'b010;  // instruction fetch is always a full word
          ifu_ar_ready    = io_axi_ar_ready;
          if (ifu_ar_valid && io_axi_ar_ready) addr_done_d = 1'b1;
        end
        ifu_r_valid    = io_axi_r_valid;
        ifu_r_data     = io_axi_r_data;
        io_axi_r_ready = ifu_r_ready;
        if (io_axi_r_valid && ifu_r_ready) begin
          state_d     = StIdle;
          addr_done_d = 1'b0;
        end
      end

      StLsuRd: begin
        if (!addr_done_q) begin
          io_axi_ar_valid = lsu_ar_valid;
          io_axi_ar_addr  = lsu_ar_addr;
          io_axi_ar_strb  = lsu_ar_strb;
          lsu_ar_ready    = io_axi_ar_ready;
          if (lsu_ar_valid && io_axi_ar_ready) addr_done_d = 1'b1;
        end
        lsu_r_valid    = io_axi_r_valid;
        lsu_r_data     = io_axi_r_data;
        io_axi_r_ready = lsu_r_ready;
        if (io_axi_r_valid && lsu_r_ready) begin
          state_d     = StIdle;
          addr_done_d = 1'b0;
        end
      end

      StLsuWr: begin
        if (!aw_done_q) begin
          io_axi_aw_valid = lsu_aw_valid;
          io_axi_aw_addr  = lsu_aw_addr;
          lsu_aw_ready    = io_axi_aw_ready;
          aw_hs           = lsu_aw_valid & io_axi_aw_ready;
        end
        if (!w_done_q) begin
          io_axi_w_valid = lsu_w_valid;
          io_axi_w_data  = lsu_w_data;
          io_axi_w_strb  = lsu_w_strb;
          lsu_w_ready    = io_axi_w_ready;
          w_hs           = lsu_w_valid & io_axi_w_ready;
        end
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // The response may complete in the same cycle as the last address/data handshake.
        wr_both_done   = (aw_done_q | aw_hs) & (w_done_q | w_hs);
        lsu_b_valid    = io_axi_b_valid & wr_both_done;
        io_axi_b_ready = lsu_b_ready & wr_both_done;
        lsu_b_resp     = io_axi_b_resp;
        if (io_axi_b_valid && io_axi_b_ready) begin
          state_d   = StIdle;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_done_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_done_q <= addr_done_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_25030077_arbiter.sv
// Directed self-checking bench for ysyx_25030077_arbiter; covers ARB_ROUND_ROBIN_EN when defined.
module tb_ysyx_25030077_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
  logic [31:0] ifu_ar_addr, ifu_r_data;
  logic        lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
  logic [31:0] lsu_ar_addr, lsu_r_data;
  logic [2:0]  lsu_ar_strb;
  logic        lsu_aw_valid, lsu_aw_ready, lsu_w_valid, lsu_w_ready;
  logic [31:0] lsu_aw_addr, lsu_w_data;
  logic [2:0]  lsu_w_strb;
  logic        lsu_b_valid, lsu_b_ready;
  logic [1:0]  lsu_b_resp;
  logic        io_axi_ar_valid, io_axi_ar_ready, io_axi_r_valid, io_axi_r_ready;
  logic [31:0] io_axi_ar_addr, io_axi_r_data;
  logic [2:0]  io_axi_ar_strb;
  logic        io_axi_aw_valid, io_axi_aw_ready, io_axi_w_valid, io_axi_w_ready;
  logic [31:0] io_axi_aw_addr, io_axi_w_data;
  logic [2:0]  io_axi_w_strb;
  logic        io_axi_b_valid, io_axi_b_ready;
  logic [1:0]  io_axi_b_resp;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ysyx_25030077_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
    .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data),
    .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
    .lsu_ar_strb(lsu_ar_strb),
    .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data),
    .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
    .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data),
    .lsu_w_strb(lsu_w_strb),
    .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
    .io_axi_ar_valid(io_axi_ar_valid), .io_axi_ar_ready(io_axi_ar_ready),
    .io_axi_ar_addr(io_axi_ar_addr), .io_axi_ar_strb(io_axi_ar_strb),
    .io_axi_r_valid(io_axi_r_valid), .io_axi_r_ready(io_axi_r_ready),
    .io_axi_r_data(io_axi_r_data),
    .io_axi_aw_valid(io_axi_aw_valid), .io_axi_aw_ready(io_axi_aw_ready),
    .io_axi_aw_addr(io_axi_aw_addr),
    .io_axi_w_valid(io_axi_w_valid), .io_axi_w_ready(io_axi_w_ready),
    .io_axi_w_data(io_axi_w_data), .io_axi_w_strb(io_axi_w_strb),
    .io_axi_b_valid(io_axi_b_valid), .io_axi_b_ready(io_axi_b_ready),
    .io_axi_b_resp(io_axi_b_resp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_ar_valid = 0; ifu_ar_addr = 0; ifu_r_ready = 0;
    lsu_ar_valid = 0; lsu_ar_addr = 0; lsu_ar_strb = 0; lsu_r_ready = 0;
    lsu_aw_valid = 0; lsu_aw_addr = 0; lsu_w_valid = 0; lsu_w_data = 0; lsu_w_strb = 0;
    lsu_b_ready = 0;
    io_axi_ar_ready = 0; io_axi_r_valid = 0; io_axi_r_data = 0;
    io_axi_aw_ready = 0; io_axi_w_ready = 0; io_axi_b_valid = 0; io_axi_b_resp = 0;
  endtask

  function automatic logic any_output();
    return ifu_ar_ready | ifu_r_valid | (|ifu_r_data) | lsu_ar_ready | lsu_r_valid |
           (|lsu_r_data) | lsu_aw_ready | lsu_w_ready | lsu_b_valid | (|lsu_b_resp) |
           io_axi_ar_valid | (|io_axi_ar_addr) | (|io_axi_ar_strb) | io_axi_r_ready |
           io_axi_aw_valid | (|io_axi_aw_addr) | io_axi_w_valid | (|io_axi_w_data) |
           (|io_axi_w_strb) | io_axi_b_ready;
  endfunction

  initial begin
    // Reset held with every request and response asserted
    clear_inputs();
    reset = 0;
    ifu_ar_valid = 1; ifu_ar_addr = 32'h1234_5678; ifu_r_ready = 1;
    lsu_ar_valid = 1; lsu_ar_addr = 32'h1111_1111; lsu_ar_strb = 3'h2; lsu_r_ready = 1;
    lsu_aw_valid = 1; lsu_aw_addr = 32'h2222_2222; lsu_w_valid = 1; lsu_w_data = 32'h3333_3333;
    lsu_w_strb = 3'h2; lsu_b_ready = 1;
    io_axi_ar_ready = 1; io_axi_r_valid = 1; io_axi_r_data = 32'h4444_4444;
    io_axi_aw_ready = 1; io_axi_w_ready = 1; io_axi_b_valid = 1; io_axi_b_resp = 2'b11;
    tick(); tick();
    check("reset_outputs_zero", any_output(), 1'b0);
    check("reset_ifu_ar_ready", ifu_ar_ready, 1'b0);

    // IFU read alone, requested as reset releases
    clear_inputs();
    ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0000; ifu_r_ready = 1;
    #1 reset = 1;
    #1 check("idle_before_grant", io_axi_ar_valid, 1'b0);
    tick();
    check("ifu_ar_fwd_valid", io_axi_ar_valid, 1'b1);
    check("ifu_ar_fwd_addr", io_axi_ar_addr, 32'h8000_0000);
    check("ifu_ar_ready_wait", ifu_ar_ready, 1'b0);
    io_axi_ar_ready = 1;
    #1 check("ifu_ar_ready_pass", ifu_ar_ready, 1'b1);
    tick();
    ifu_ar_valid = 0; io_axi_ar_ready = 0;
    io_axi_r_valid = 1; io_axi_r_data = 32'h0000_0413; lsu_r_ready = 1;
    #1 check("ifu_ar_done_quiet", io_axi_ar_valid, 1'b0);
    check("ifu_r_valid", ifu_r_valid, 1'b1);
    check("ifu_r_data", ifu_r_data, 32'h0000_0413);
    check("ifu_r_no_cross", lsu_r_valid, 1'b0);
    check("ifu_r_ready_fwd", io_axi_r_ready, 1'b1);
    tick();
    // Still-valid response in IDLE must not be acked
    check("idle_r_not_acked", io_axi_r_ready, 1'b0);
    check("idle_ifu_r_valid", ifu_r_valid, 1'b0);
    clear_inputs();
    tick();

    // LSU write with w before aw
    lsu_w_valid = 1; lsu_w_data = 32'hDEAD_BEEF; lsu_w_strb = 3'h2; lsu_b_ready = 1;
    tick();
    check("wr_w_valid", io_axi_w_valid, 1'b1);
    check("wr_w_data", io_axi_w_data, 32'hDEAD_BEEF);
    check("wr_w_strb", io_axi_w_strb, 3'h2);
    check("wr_aw_idle", io_axi_aw_valid, 1'b0);
    check("wr_b_gated0", io_axi_b_ready, 1'b0);
    io_axi_w_ready = 1;
    #1 check("wr_w_ready", lsu_w_ready, 1'b1);
    tick();
    lsu_w_valid = 0; io_axi_w_ready = 0;
    lsu_aw_valid = 1; lsu_aw_addr = 32'ha000_03f8; io_axi_b_valid = 1; io_axi_b_resp = 2'b10;
    #1 check("wr_w_done_quiet", io_axi_w_valid, 1'b0);
    check("wr_aw_valid", io_axi_aw_valid, 1'b1);
    check("wr_aw_addr", io_axi_aw_addr, 32'ha000_03f8);
    check("wr_b_gated1", io_axi_b_ready, 1'b0);
    check("wr_b_valid_gated", lsu_b_valid, 1'b0);
    io_axi_b_valid = 0;
    io_axi_aw_ready = 1;
    #1 check("wr_b_ready_same_cycle", io_axi_b_ready, 1'b1);
    tick();
    lsu_aw_valid = 0; io_axi_aw_ready = 0;
    io_axi_b_valid = 1; io_axi_b_resp = 2'b00;
    #1 check("wr_b_valid", lsu_b_valid, 1'b1);
    check("wr_b_resp", lsu_b_resp, 2'b00);
    check("wr_b_ready", io_axi_b_ready, 1'b1);
    tick();
    check("idle_b_not_acked", io_axi_b_ready, 1'b0);
    clear_inputs();
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    // Fresh reset so last_gnt is IFU; both masters keep requesting
    reset = 0;
    #1 reset = 1;
    ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0100; ifu_r_ready = 1;
    lsu_ar_valid = 1; lsu_ar_addr = 32'h1000_0200; lsu_ar_strb = 3'h2; lsu_r_ready = 1;
    io_axi_ar_ready = 1; io_axi_r_valid = 1; io_axi_r_data = 32'h0000_00aa;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_grant%0d_addr", i), io_axi_ar_addr,
            (i % 2 == 0) ? 32'h1000_0200 : 32'h8000_0100);
      tick();
    end
    clear_inputs();
    tick();
`else
    // Simultaneous IFU and LSU reads: LSU first
    ifu_ar_valid = 1; ifu_ar_addr = 32'h8000_0004; ifu_r_ready = 1;
    lsu_ar_valid = 1; lsu_ar_addr = 32'h1000_0000; lsu_ar_strb = 3'h1; lsu_r_ready = 1;
    tick();
    io_axi_ar_ready = 1;
    #1 check("cont_lsu_addr", io_axi_ar_addr, 32'h1000_0000);
    check("cont_lsu_strb", io_axi_ar_strb, 3'h1);
    check("cont_lsu_ar_ready", lsu_ar_ready, 1'b1);
    check("cont_ifu_ar_blocked", ifu_ar_ready, 1'b0);
    tick();
    lsu_ar_valid = 0; io_axi_ar_ready = 0;
    io_axi_r_valid = 1; io_axi_r_data = 32'h0000_0055;
    #1 check("cont_lsu_r_data", lsu_r_data, 32'h0000_0055);
    check("cont_ifu_r_no_cross", ifu_r_valid, 1'b0);
    check("cont_ifu_ar_blocked2", ifu_ar_ready, 1'b0);
    tick();
    io_axi_r_valid = 0;
    #1 check("cont_idle_gap", io_axi_ar_valid, 1'b0);
    tick();
    check("cont_ifu_addr", io_axi_ar_addr, 32'h8000_0004);
    io_axi_ar_ready = 1; io_axi_r_valid = 1; io_axi_r_data = 32'h0000_0099;
    #1 check("cont_ifu_ar_ready", ifu_ar_ready, 1'b1);
    check("cont_ifu_r_data", ifu_r_data, 32'h0000_0099);
    tick();
    clear_inputs();
    #1 check("cont_back_idle", io_axi_ar_valid, 1'b0);
    tick();
`endif

    // Reset during LSU_WR after aw_done
    lsu_aw_valid = 1; lsu_aw_addr = 32'ha000_0000; lsu_w_valid = 1; lsu_w_data = 32'h0bad_cafe;
    lsu_b_ready = 1;
    tick();
    io_axi_aw_ready = 1;
    tick();
    lsu_aw_valid = 0; io_axi_aw_ready = 0;
    #1 check("mid_w_valid_before", io_axi_w_valid, 1'b1);
    reset = 0;
    #1 check("mid_reset_w_dropped", io_axi_w_valid, 1'b0);
    tick();
    lsu_w_valid = 0; reset = 1; io_axi_b_valid = 1;
    #1 check("mid_reset_b_not_acked0", io_axi_b_ready, 1'b0);
    tick();
    check("mid_reset_b_not_acked1", io_axi_b_ready, 1'b0);
    check("mid_reset_lsu_b_valid", lsu_b_valid, 1'b0);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
